// File: rtl/pipe_step_ctrl_if.sv
// Control bundle of the step sequencer: key/auto-step requests in, step pulses and FSM state out.
// Every output is registered inside the sequencer; no handshake, the consumer must take each pulse as it comes.
interface pipe_step_ctrl_if;
    logic       key_n;
    logic       auto_en;
    logic       step;
    logic       latch_op;
    logic       en_s1;
    logic       en_s2;
    logic       op_hold;
    logic [1:0] state;

    modport master (
        output key_n,
        output auto_en,
        input  step,
        input  latch_op,
        input  en_s1,
        input  en_s2,
        input  op_hold,
        input  state
    );

    modport slave (
        input  key_n,
        input  auto_en,
        output step,
        output latch_op,
        output en_s1,
        output en_s2,
        output op_hold,
        output state
    );
endinterface

// File: rtl/pipe_step_ctrl.sv
// Debounced push-button (plus optional AUTO_STEP_EN timer) stepping the two-stage adder pipeline; step lands DEBOUNCE_CYCLES+3 edges after press.
// No backpressure: pulses are one cycle wide, and a step arriving while in LOAD is dropped.
module pipe_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1048575,
    parameter int unsigned DB_W            = 20,
    parameter int unsigned AUTO_PERIOD     = 50000000,
    parameter int unsigned AUTO_W          = 26
) (
    input  logic            clk,
    input  logic            rst,
    pipe_step_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        S1   = 2'd2,
        S2   = 2'd3
    } state_t;

    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

    logic            key_s1;
    logic            k_s;
    logic [DB_W-1:0] db_cnt;
    logic            db;
    logic            db_d;
    logic            key_ev;
    logic            tick;

    logic            step_q;
    logic            latch_q;
    logic            en_s1_q;
    logic            en_s2_q;
    logic            hold_q;
    state_t          state_q;

    // Two-flop synchronizer; inverted so k_s = 1 means pressed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_s1 <= 1'b0;
            k_s    <= 1'b0;
        end else begin
            key_s1 <= ~bus.key_n;
            k_s    <= key_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt <= '0;
        end else if (!k_s) begin
            db_cnt <= '0;
        end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // db drops in the same cycle the synchronized key reads released.
    assign db = k_s && (db_cnt == DB_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_d <= 1'b0;
        end else begin
            db_d <= db;
        end
    end

    assign key_ev = db & ~db_d;

`ifdef AUTO_STEP_EN
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

    logic [AUTO_W-1:0] auto_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            auto_cnt <= '0;
        end else if (!bus.auto_en) begin
            auto_cnt <= '0;
        end else if (auto_cnt == AUTO_LAST) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + AUTO_W'(1);
        end
    end

    assign tick = bus.auto_en && (auto_cnt == AUTO_LAST);
`else
    logic [AUTO_W-1:0] unused_auto_cfg;

    assign unused_auto_cfg = AUTO_W'(AUTO_PERIOD) ^ {{(AUTO_W-1){1'b0}}, bus.auto_en};
    assign tick            = 1'b0;
`endif

    // The FSM reacts to the registered step, so latch_op trails step by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q  <= 1'b0;
            latch_q <= 1'b0;
            en_s1_q <= 1'b0;
            en_s2_q <= 1'b0;
            hold_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            step_q  <= key_ev | tick;
            latch_q <= 1'b0;
            en_s1_q <= 1'b0;
            en_s2_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (step_q) begin
                        latch_q <= 1'b1;
                        hold_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    en_s1_q <= 1'b1;
                    hold_q  <= 1'b1;
                    state_q <= S1;
                end
                S1: begin
                    if (step_q) begin
                        en_s2_q <= 1'b1;
                        hold_q  <= 1'b0;
                        state_q <= S2;
                    end
                end
                S2: begin
                    if (step_q) begin
                        latch_q <= 1'b1;
                        hold_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                default: begin
                    hold_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.step     = step_q;
    assign bus.latch_op = latch_q;
    assign bus.en_s1    = en_s1_q;
    assign bus.en_s2    = en_s2_q;
    assign bus.op_hold  = hold_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Directed bench for pipe_step_ctrl with DEBOUNCE_CYCLES = 4 and AUTO_PERIOD = 5.
module tb_pipe_step_ctrl;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pipe_step_ctrl_if pif();

    pipe_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DB_W           (3),
        .AUTO_PERIOD    (5),
        .AUTO_W         (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(pif)
    );

    // {step, latch_op, en_s1, en_s2, op_hold, state}
    logic [6:0] obs;
    assign obs = {pif.step, pif.latch_op, pif.en_s1, pif.en_s2, pif.op_hold, pif.state};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want summary");
        $fatal(1);
    end

    task automatic do_reset();
        rst         = 1'b0;
        pif.key_n   = 1'b1;
        pif.auto_en = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        pif.key_n   = 1'b1;
        pif.auto_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", obs, 7'd0);
        end
        #3 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== 7'd0) begin
            errors++;
            $display("FAIL reset_release_idle: got %b want %b", obs, 7'd0);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int e = 0; e < 50; e++) begin
            pif.key_n = (e >= 40) ? 1'b1 : (((e / 2) % 2) == 0 ? 1'b0 : 1'b1);
            @(posedge clk);
            #1;
            checks++;
            if (obs !== 7'd0) begin
                errors++;
                $display("FAIL bounce cyc=%0d: got %b want %b", e, obs, 7'd0);
            end
        end
    endtask

    task automatic test_key_latency();
        logic [6:0] exp;
        int         st;
        pif.key_n = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            st  = (e < 8) ? 0 : ((e == 8) ? 1 : 2);
            exp = {e == 7, e == 8, e == 9, 1'b0, e >= 8, 2'(st)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL key_latency edge=%0d: got %b want %b", e, obs, exp);
            end
        end
        pif.key_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        logic [6:0] exp;
        int         st;
        checks++;
        if (pif.state !== 2'd2) begin
            errors++;
            $display("FAIL mid_reset_pre_state: got %0d want 2", pif.state);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (obs !== 7'd0) begin
            errors++;
            $display("FAIL mid_reset_async: got %b want %b", obs, 7'd0);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 7'd0) begin
            errors++;
            $display("FAIL mid_reset_release: got %b want %b", obs, 7'd0);
        end
        pif.key_n = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            st  = (e < 8) ? 0 : ((e == 8) ? 1 : 2);
            exp = {e == 7, e == 8, e == 9, 1'b0, e >= 8, 2'(st)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mid_reset_restart edge=%0d: got %b want %b", e, obs, exp);
            end
        end
        pif.key_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_pending();
        logic [6:0] exp;
        do_reset();
        pif.key_n = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (obs !== 7'b0100101) begin
            errors++;
            $display("FAIL pending_pre_load: got %b want %b", obs, 7'b0100101);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs !== 7'd0) begin
            errors++;
            $display("FAIL pending_async: got %b want %b", obs, 7'd0);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        // key stays held through release: a fresh debounce count is needed
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            exp = {e == 7, e == 8, 1'b0, 1'b0, e == 8, (e == 8) ? 2'd1 : 2'd0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL pending_held_key edge=%0d: got %b want %b", e, obs, exp);
            end
        end
        pif.key_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_full_cycle();
        int         pulses[$];
        int         states[$];
        int         exp_seq[6] = '{1, 2, 3, 1, 2, 3};
        int         hold_bad   = 0;
        int         multi      = 0;
        logic [1:0] last       = 2'd0;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            pif.key_n = 1'b0;
            for (int c = 0; c < 16; c++) begin
                if (c == 10) pif.key_n = 1'b1;
                @(posedge clk);
                #1;
                if (pif.latch_op === 1'b1) pulses.push_back(1);
                if (pif.en_s1 === 1'b1) pulses.push_back(2);
                if (pif.en_s2 === 1'b1) pulses.push_back(3);
                if ((int'(pif.latch_op) + int'(pif.en_s1) + int'(pif.en_s2)) > 1) multi++;
                if (pif.op_hold !== ((pif.state == 2'd1) || (pif.state == 2'd2))) hold_bad++;
                if (pif.state !== last) begin
                    states.push_back(int'(pif.state));
                    last = pif.state;
                end
            end
        end
        checks++;
        if (pulses.size() != 6) begin
            errors++;
            $display("FAIL full_pulse_count: got %0d want 6", pulses.size());
        end
        checks++;
        if (states.size() != 6) begin
            errors++;
            $display("FAIL full_state_count: got %0d want 6", states.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= pulses.size() || pulses[i] != exp_seq[i]) begin
                errors++;
                $display("FAIL full_pulse_order idx=%0d: got %0d want %0d", i,
                         (i < pulses.size()) ? pulses[i] : -1, exp_seq[i]);
            end
            checks++;
            if (i >= states.size() || states[i] != exp_seq[i]) begin
                errors++;
                $display("FAIL full_state_order idx=%0d: got %0d want %0d", i,
                         (i < states.size()) ? states[i] : -1, exp_seq[i]);
            end
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL full_op_hold: got %0d bad cycles want 0", hold_bad);
        end
        checks++;
        if (multi != 0) begin
            errors++;
            $display("FAIL full_onehot: got %0d overlapping cycles want 0", multi);
        end
    endtask

`ifdef AUTO_STEP_EN
    task automatic test_auto();
        logic [6:0] exp;
        int         st;
        do_reset();
        for (int e = -2; e <= 34; e++) begin
            pif.key_n   = (e == 3) ? 1'b1 : 1'b0;
            pif.auto_en = (e >= 1 && e <= 30) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            if (e < 5) st = 0;
            else if (e == 5 || e == 16 || e == 26) st = 1;
            else if ((e >= 6 && e <= 10) || (e >= 17 && e <= 20) || (e >= 27 && e <= 30)) st = 2;
            else st = 3;
            exp = {(e == 4 || e == 5 || e == 10 || e == 15 || e == 20 || e == 25 || e == 30),
                   (e == 5 || e == 16 || e == 26),
                   (e == 6 || e == 17 || e == 27),
                   (e == 11 || e == 21 || e == 31),
                   (st == 1 || st == 2),
                   2'(st)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL auto edge=%0d: got %b want %b", e, obs, exp);
            end
        end
        pif.key_n   = 1'b1;
        pif.auto_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask
`else
    task automatic test_macro_off();
        do_reset();
        pif.auto_en = 1'b1;
        for (int e = 0; e < 100; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== 7'd0) begin
                errors++;
                $display("FAIL macro_off cyc=%0d: got %b want %b", e, obs, 7'd0);
            end
        end
        pif.auto_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_bounce();
        test_key_latency();
        test_reset_mid_run();
        test_reset_pending();
        test_full_cycle();
`ifdef AUTO_STEP_EN
        test_auto();
`else
        test_macro_off();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
